rvvi_ack_rx: RTL and testbench



---
 rtl/rvvi_ack_rx.sv | 167 ++++++++++++++++
 tb/tb_rvvi_ack_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_ack_rx.sv
// Host acknowledgement frame receiver for the RVVI trace link.
// Recovers acked Minstret / host load and throttles the core.
module rvvi_ack_rx #(
  parameter logic [15:0] ETHERTYPE     = 16'h005C,
  parameter logic [63:0] STALL_THRESH  = 64'd64,
  parameter logic [63:0] RESUME_THRESH = 64'd16,
  parameter logic [31:0] TIMEOUT       = 32'd100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RxTdata,
  input  logic [3:0]  RxTkeep,
  input  logic        RxTvalid,
  input  logic        RxTlast,
  output logic        RxTready,
  input  logic [63:0] Minstret,
  output logic        AckValid,
  output logic [63:0] AckMinstret,
  output logic [31:0] HostLoad,
  output logic [63:0] Outstanding,
  output logic        ExternalStall,
  output logic        TimeoutStall,
  output logic [15:0] GoodFrameCount,
  output logic [15:0] BadFrameCount
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DISCARD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_rdy;
  logic        r_ackv;
  logic        r_stall;
  logic [63:0] r_ack;
  logic [63:0] r_out;
  logic [31:0] r_load;
  logic [31:0] r_wd;
  logic [15:0] r_good;
  logic [15:0] r_bad;
  logic [15:0] r_w3;
  logic [31:0] r_w4;
  logic [31:0] r_w5;

  logic        w_beat;
  logic        w_bad;
  logic        w_cand;
  logic        w_fresh;
  logic        w_ok;
  logic        w_stale;
  logic        w_tmo;
  logic [63:0] w_new_ack;

  assign w_beat    = RxTvalid & r_rdy;
  assign w_new_ack = {r_w5[15:0], r_w4, r_w3};
  // Wrap-safe ordering: newer-or-equal when the difference is non-negative.
  assign w_fresh   = $signed(w_new_ack - r_ack) >= 64'sd0;
  assign w_ok      = w_cand & w_fresh;
  assign w_stale   = w_cand & ~w_fresh;
  assign w_tmo     = r_wd >= TIMEOUT;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_bad  = 1'b0;
    w_cand = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          if (RxTlast) w_bad  = 1'b1;
          else         w_next = RECV;
        end
      end
      RECV: begin
        if (w_beat) begin
          if (r_cnt == 3'd3 &&
              RxTdata[15:0] != ETHERTYPE) begin
            w_bad  = 1'b1;
            w_next = RxTlast ? IDLE : DISCARD;
          end else if (RxTlast) begin
            w_next = IDLE;
            if (r_cnt == 3'd6 && RxTkeep == 4'hF)
              w_cand = 1'b1;
            else
              w_bad = 1'b1;
          end else if (r_cnt == 3'd6) begin
            w_bad  = 1'b1;
            w_next = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (w_beat && RxTlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 3'd0;
      r_rdy   <= 1'b0;
      r_ackv  <= 1'b0;
      r_stall <= 1'b0;
      r_ack   <= 64'd0;
      r_out   <= 64'd0;
      r_load  <= 32'd0;
      r_wd    <= 32'd0;
      r_good  <= 16'd0;
      r_bad   <= 16'd0;
      r_w3    <= 16'd0;
      r_w4    <= 32'd0;
      r_w5    <= 32'd0;
    end else begin
      r_rdy <= 1'b1;
      if (w_beat) begin
        if (r_state == IDLE) r_cnt <= 3'd1;
        else                 r_cnt <= r_cnt + 3'd1;
        if (r_state == RECV) begin
          case (r_cnt)
            3'd3:    r_w3 <= RxTdata[31:16];
            3'd4:    r_w4 <= RxTdata;
            3'd5:    r_w5 <= RxTdata;
            default: ;
          endcase
        end
      end
      // Commit lands on the last beat's edge; word6 is still on the bus.
      r_ackv <= w_ok;
      if (w_ok) begin
        r_ack  <= w_new_ack;
        r_load <= {RxTdata[15:0], r_w5[31:16]};
        if (r_good != 16'hFFFF) r_good <= r_good + 16'd1;
      end
      if ((w_bad | w_stale) && r_bad != 16'hFFFF)
        r_bad <= r_bad + 16'd1;
      r_out <= Minstret - r_ack;
      if (r_out >= STALL_THRESH || w_tmo)
        r_stall <= 1'b1;
      else if (r_out < RESUME_THRESH)
        r_stall <= 1'b0;
      if (r_ackv || r_out == 64'd0)
        r_wd <= 32'd0;
      else if (r_wd != 32'hFFFF_FFFF)
        r_wd <= r_wd + 32'd1;
    end
  end

  assign RxTready       = r_rdy;
  assign AckValid       = r_ackv;
  assign AckMinstret    = r_ack;
  assign HostLoad       = r_load;
  assign Outstanding    = r_out;
  assign ExternalStall  = r_stall;
  assign TimeoutStall   = w_tmo;
  assign GoodFrameCount = r_good;
  assign BadFrameCount  = r_bad;

endmodule

// File: tb/tb_rvvi_ack_rx.sv
// Bench for rvvi_ack_rx: cycle model plus directed frames.
// Outputs compared on every falling edge.
module tb_rvvi_ack_rx;

  localparam logic [15:0] ETH = 16'h005C;
  localparam logic [31:0] TMO = 32'd20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] RxTdata = 32'd0;
  logic [3:0]  RxTkeep = 4'd0;
  logic        RxTvalid = 1'b0;
  logic        RxTlast = 1'b0;
  logic [63:0] Minstret = 64'd0;
  logic        RxTready;
  logic        AckValid;
  logic [63:0] AckMinstret;
  logic [31:0] HostLoad;
  logic [63:0] Outstanding;
  logic        ExternalStall;
  logic        TimeoutStall;
  logic [15:0] GoodFrameCount;
  logic [15:0] BadFrameCount;

  rvvi_ack_rx #(.TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .RxTdata(RxTdata),
    .RxTkeep(RxTkeep),
    .RxTvalid(RxTvalid),
    .RxTlast(RxTlast),
    .RxTready(RxTready),
    .Minstret(Minstret),
    .AckValid(AckValid),
    .AckMinstret(AckMinstret),
    .HostLoad(HostLoad),
    .Outstanding(Outstanding),
    .ExternalStall(ExternalStall),
    .TimeoutStall(TimeoutStall),
    .GoodFrameCount(GoodFrameCount),
    .BadFrameCount(BadFrameCount)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  nm, a, e, $time);
  endtask

  // Model state: what the outputs must be after each edge.
  logic        m_rdy = 0, m_ackv = 0, m_stall = 0;
  logic [63:0] m_ack = 0, m_out = 0;
  logic [31:0] m_load = 0, m_wd = 0;
  int          m_good = 0, m_bad = 0;
  int          idx = 0;
  logic        doomed = 0;
  logic [31:0] fw [7];
  logic [63:0] o_out, o_ack, ack_n;
  logic        o_tmo, o_ackv, n_ackv, isbad;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_rdy = 0; m_ackv = 0; m_stall = 0;
      m_ack = 0; m_out = 0; m_load = 0; m_wd = 0;
      m_good = 0; m_bad = 0; idx = 0; doomed = 0;
    end else begin
      o_out  = m_out;
      o_ack  = m_ack;
      o_ackv = m_ackv;
      o_tmo  = (m_wd >= TMO);
      n_ackv = 0;
      if (RxTvalid && m_rdy) begin
        if (!doomed) begin
          isbad = (idx == 3 && RxTdata[15:0] != ETH) ||
                  (RxTlast && idx < 6) ||
                  (idx == 6 && !(RxTlast && RxTkeep == 4'hF));
          if (isbad) begin
            if (m_bad < 65535) m_bad++;
            doomed = !RxTlast;
          end else if (idx == 6) begin
            ack_n = {fw[5][15:0], fw[4], fw[3][31:16]};
            if ($signed(ack_n - o_ack) >= 64'sd0) begin
              m_ack  = ack_n;
              m_load = {RxTdata[15:0], fw[5][31:16]};
              n_ackv = 1;
              if (m_good < 65535) m_good++;
            end else if (m_bad < 65535) m_bad++;
          end
        end
        if (idx < 7) fw[3'(idx)] = RxTdata;
        idx++;
        if (RxTlast) begin
          idx = 0;
          doomed = 0;
        end
      end
      m_out = Minstret - o_ack;
      if (o_out >= 64 || o_tmo) m_stall = 1;
      else if (o_out < 16 && !o_tmo) m_stall = 0;
      if (o_ackv || o_out == 0) m_wd = 0;
      else if (m_wd != 32'hFFFF_FFFF) m_wd++;
      m_ackv = n_ackv;
      m_rdy  = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("RxTready", 64'(RxTready), 64'(m_rdy));
    chk("AckValid", 64'(AckValid), 64'(m_ackv));
    chk("AckMinstret", AckMinstret, m_ack);
    chk("HostLoad", 64'(HostLoad), 64'(m_load));
    chk("Outstanding", Outstanding, m_out);
    chk("ExternalStall", 64'(ExternalStall), 64'(m_stall));
    chk("TimeoutStall", 64'(TimeoutStall), 64'(m_wd >= TMO));
    chk("GoodFrameCount", 64'(GoodFrameCount), 64'(m_good));
    chk("BadFrameCount", 64'(BadFrameCount), 64'(m_bad));
  end

  function automatic logic [31:0] fword(input logic [63:0] a,
      input logic [31:0] ld, input logic [15:0] et, input int i);
    case (i)
      3:       fword = {a[15:0], et};
      4:       fword = a[47:16];
      5:       fword = {ld[15:0], a[63:48]};
      6:       fword = {16'hBEEF, ld[31:16]};
      default: fword = 32'hA5A5_0000 | 32'(i);
    endcase
  endfunction

  task automatic drv(input logic [31:0] d, input logic l,
                     input logic [3:0] k);
    @(negedge clk);
    RxTvalid = 1; RxTdata = d; RxTlast = l; RxTkeep = k;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxTvalid = 0; RxTlast = 0; RxTdata = 0; RxTkeep = 0;
    end
  endtask

  task automatic frame(input logic [63:0] a, input logic [31:0] ld,
      input logic [15:0] et, input int n, input logic [3:0] k6);
    for (int i = 0; i < n; i++)
      drv(fword(a, ld, et, i), i == n - 1, (i == 6) ? k6 : 4'hF);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    repeat (3) @(negedge clk);
    chk("lit_rst_ready", 64'(RxTready), 0);
    chk("lit_rst_ack", AckMinstret, 0);
    chk("lit_rst_bad", 64'(BadFrameCount), 0);
    reset = 0;
    @(negedge clk);
    chk("lit_ready_up", 64'(RxTready), 1);

    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      Minstret = 64'(8 * i);
    end
    chk("lit_stall_on", 64'(ExternalStall), 1);
    chk("lit_out_72", Outstanding, 64'd72);
    frame(64'd70, 32'h0000_0046, ETH, 7, 4'hF);
    idle(1);
    chk("lit_ack70_valid", 64'(AckValid), 1);
    chk("lit_ack70", AckMinstret, 64'd70);
    chk("lit_good1", 64'(GoodFrameCount), 1);
    idle(4);
    chk("lit_stall_off", 64'(ExternalStall), 0);
    chk("lit_out_10", Outstanding, 64'd10);
    frame(64'd50, 32'h0000_0032, ETH, 7, 4'hF);
    idle(2);
    chk("lit_stale_bad", 64'(BadFrameCount), 1);
    chk("lit_stale_keep", AckMinstret, 64'd70);

    Minstret = 64'd70;
    frame(64'd70, 32'h1234_5678, ETH, 7, 4'hF);
    idle(1);
    chk("lit_equal_valid", 64'(AckValid), 1);
    chk("lit_equal_load", 64'(HostLoad), 64'h1234_5678);
    chk("lit_good2", 64'(GoodFrameCount), 2);

    frame(64'd99, 32'h0, 16'h0800, 7, 4'hF);
    idle(1);
    chk("lit_eth_bad", 64'(BadFrameCount), 2);
    chk("lit_eth_novalid", 64'(AckValid), 0);
    Minstret = 64'd100;
    frame(64'd100, 32'h0000_0100, ETH, 7, 4'hF);
    idle(1);
    chk("lit_after_eth", AckMinstret, 64'd100);

    Minstret = 64'd120;
    frame(64'd110, 32'h0000_0110, ETH, 7, 4'hF);
    frame(64'd120, 32'hCAFE_F00D, ETH, 7, 4'hF);
    idle(1);
    chk("lit_b2b_ack", AckMinstret, 64'd120);
    chk("lit_b2b_load", 64'(HostLoad), 64'hCAFE_F00D);
    chk("lit_b2b_good", 64'(GoodFrameCount), 5);

    frame(64'd130, 32'h0, ETH, 5, 4'hF);
    frame(64'd130, 32'h0, ETH, 9, 4'hF);
    frame(64'd120, 32'h0000_0777, ETH, 7, 4'hF);
    idle(1);
    chk("lit_len_bad", 64'(BadFrameCount), 4);
    chk("lit_len_load", 64'(HostLoad), 64'h0000_0777);
    frame(64'd120, 32'h0, ETH, 7, 4'h7);
    frame(64'd120, 32'h0, ETH, 1, 4'hF);
    idle(1);
    chk("lit_keep_bad", 64'(BadFrameCount), 6);

    for (int i = 0; i < 3; i++)
      drv(fword(64'd5, 32'h0, ETH, i), 0, 4'hF);
    @(negedge clk);
    reset = 1; Minstret = 64'd5;
    RxTvalid = 1; RxTdata = fword(64'd5, 32'h0, ETH, 3);
    idle(1);
    chk("lit_mid_good", 64'(GoodFrameCount), 0);
    chk("lit_mid_bad", 64'(BadFrameCount), 0);
    chk("lit_mid_ack", AckMinstret, 0);
    chk("lit_mid_stall", 64'(ExternalStall), 0);
    reset = 0;
    idle(20);
    chk("lit_tmo_pre", 64'(TimeoutStall), 0);
    idle(1);
    chk("lit_tmo_on", 64'(TimeoutStall), 1);
    idle(1);
    chk("lit_tmo_stall", 64'(ExternalStall), 1);
    frame(64'd5, 32'h0000_0055, ETH, 7, 4'hF);
    idle(1);
    chk("lit_tmo_ackv", 64'(AckValid), 1);
    chk("lit_tmo_hold", 64'(TimeoutStall), 1);
    idle(1);
    chk("lit_tmo_clr", 64'(TimeoutStall), 0);
    idle(1);
    chk("lit_tmo_stall_clr", 64'(ExternalStall), 0);

    Minstret = 64'h0000_0001_2345_6789;
    frame(64'h0000_0001_2345_6789, 32'hABCD_0001, ETH, 7, 4'hF);
    idle(1);
    chk("lit_big_valid", 64'(AckValid), 1);
    chk("lit_big_ack", AckMinstret, 64'h0000_0001_2345_6789);
    chk("lit_big_load", 64'(HostLoad), 64'hABCD_0001);
    chk("lit_big_good", 64'(GoodFrameCount), 2);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
